// File: rtl/router_ctrl_fsm_if.sv
// Control bundle between the router packet-sequencing FSM and its neighbours.
// Inputs come from the input port, router_sync and router_reg; outputs steer router_reg and the FIFO write path.
interface router_ctrl_fsm_if #(
    parameter int N_PORTS = 3
);
    logic               pkt_valid;
    logic [1:0]         data_in;
    logic               fifo_full;
    logic [N_PORTS-1:0] fifo_empty;
    logic [N_PORTS-1:0] soft_reset;
    logic               parity_done;
    logic               low_packet_valid;

    logic               detect_add;
    logic               lfd_state;
    logic               ld_state;
    logic               full_state;
    logic               laf_state;
    logic               rst_int_reg;
    logic               write_enb_reg;
    logic               busy;
    logic [1:0]         sel_addr;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, sel_addr
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, sel_addr
    );
endinterface

// File: rtl/router_ctrl_fsm.sv
// Moore packet-sequencing controller for the 1x3 router: header decode, FIFO stall handling,
// parity sequencing and abort on destination soft reset. All flags decode from the state register.
module router_ctrl_fsm #(
    parameter int N_PORTS = 3
) (
    input logic              clock,
    input logic              reset,
    router_ctrl_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [2:0] N_PORTS_W = 3'(N_PORTS);

    state_t     state;
    state_t     state_next;
    logic [1:0] sel_addr;
    logic [3:0] empty_pad;
    logic [3:0] soft_pad;
    logic       addr_valid;
    logic       hdr_accept;
    logic       abort;

    // Pad per-port vectors to the full 2-bit address range so an invalid address never indexes out of bounds.
    assign empty_pad  = 4'(bus.fifo_empty);
    assign soft_pad   = 4'(bus.soft_reset);
    assign addr_valid = ({1'b0, bus.data_in} < N_PORTS_W);
    assign hdr_accept = (state == DECODE_ADDRESS) && bus.pkt_valid && addr_valid;
    assign abort      = (state != DECODE_ADDRESS) && soft_pad[sel_addr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_addr <= 2'd0;
        end else if (hdr_accept) begin
            sel_addr <= bus.data_in;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = DECODE_ADDRESS;
        end else begin
            unique case (state)
                DECODE_ADDRESS: begin
                    if (hdr_accept) begin
                        state_next = empty_pad[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_next = LOAD_DATA;
                LOAD_DATA: begin
                    // Full takes precedence: busy holds the parity byte until space frees up.
                    if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) state_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)           state_next = DECODE_ADDRESS;
                    else if (bus.low_packet_valid) state_next = LOAD_PARITY;
                    else                           state_next = LOAD_DATA;
                end
                LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_pad[sel_addr]) state_next = LOAD_FIRST_DATA;
                end
                default: state_next = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                               (state == LOAD_AFTER_FULL);
    assign bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
    assign bus.sel_addr      = sel_addr;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: walks each state path and compares the decoded flag
// vector and sel_addr against hand-derived expectations.
module tb_router_ctrl_fsm;

    // Flag vector order: detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy
    localparam logic [7:0] S_DEC  = 8'b1000_0000;
    localparam logic [7:0] S_LFD  = 8'b0100_0001;
    localparam logic [7:0] S_LD   = 8'b0010_0010;
    localparam logic [7:0] S_FULL = 8'b0001_0001;
    localparam logic [7:0] S_LAF  = 8'b0000_1011;
    localparam logic [7:0] S_LP   = 8'b0000_0011;
    localparam logic [7:0] S_CPE  = 8'b0000_0101;
    localparam logic [7:0] S_WTE  = 8'b0000_0001;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   wr_count;

    router_ctrl_fsm_if #(.N_PORTS(3)) bus ();

    router_ctrl_fsm #(.N_PORTS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] flags();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, compare the state flags.
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clock);
        #1;
        check(tag, flags(), exp);
        if (bus.write_enb_reg === 1'b1) wr_count++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_count = 0;
        reset                = 1'b1;
        bus.pkt_valid        = 1'b0;
        bus.data_in          = 2'd0;
        bus.fifo_full        = 1'b0;
        bus.fifo_empty       = 3'b111;
        bus.soft_reset       = 3'b000;
        bus.parity_done      = 1'b0;
        bus.low_packet_valid = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("reset_flags", flags(), S_DEC);
        check("reset_sel", 8'(bus.sel_addr), 8'd0);
        reset = 1'b0;
        step("idle_dec", S_DEC);

        // Normal packet to port 1: DEC, LFD, LD x4, LP, CPE, DEC
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd1;
        wr_count      = 0;
        step("pkt_lfd", S_LFD);
        check("pkt_sel", 8'(bus.sel_addr), 8'd1);
        step("pkt_ld1", S_LD);
        step("pkt_ld2", S_LD);
        step("pkt_ld3", S_LD);
        step("pkt_ld4", S_LD);
        bus.pkt_valid = 1'b0;
        step("pkt_lp", S_LP);
        step("pkt_cpe", S_CPE);
        step("pkt_dec", S_DEC);
        check("pkt_writes", 8'(wr_count), 8'd5);

        // Async reset in the middle of LOAD_DATA
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd2;
        step("rst_lfd", S_LFD);
        step("rst_ld", S_LD);
        check("rst_sel_pre", 8'(bus.sel_addr), 8'd2);
        #1 reset = 1'b1;
        #1;
        check("rst_async_flags", flags(), S_DEC);
        check("rst_async_sel", 8'(bus.sel_addr), 8'd0);
        reset         = 1'b0;
        bus.pkt_valid = 1'b0;
        step("rst_release", S_DEC);

        // Destination not empty -> wait, then proceed once it drains
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'd2;
        bus.fifo_empty = 3'b011;
        step("wte_enter", S_WTE);
        check("wte_sel", 8'(bus.sel_addr), 8'd2);
        step("wte_hold", S_WTE);
        bus.fifo_empty = 3'b111;
        step("wte_lfd", S_LFD);
        step("wte_ld", S_LD);

        // FIFO full for three cycles, resume, then full wins over parity byte
        bus.fifo_full = 1'b1;
        step("full_1", S_FULL);
        step("full_2", S_FULL);
        step("full_3", S_FULL);
        bus.fifo_full = 1'b0;
        step("laf_1", S_LAF);
        step("laf_to_ld", S_LD);
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        step("full_wins", S_FULL);
        bus.fifo_full = 1'b0;
        step("laf_2", S_LAF);
        bus.low_packet_valid = 1'b1;
        step("laf_to_lp", S_LP);
        bus.low_packet_valid = 1'b0;
        bus.fifo_full        = 1'b1;
        step("lp_to_cpe", S_CPE);
        step("cpe_to_full", S_FULL);
        bus.fifo_full = 1'b0;
        step("laf_3", S_LAF);
        bus.parity_done = 1'b1;
        step("laf_to_dec", S_DEC);
        bus.parity_done = 1'b0;

        // Invalid address 3 is ignored
        bus.pkt_valid = 1'b1;
        bus.data_in   = 2'd3;
        wr_count      = 0;
        for (int i = 0; i < 4; i++) step("bad_addr", S_DEC);
        check("bad_addr_sel", 8'(bus.sel_addr), 8'd2);
        check("bad_addr_writes", 8'(wr_count), 8'd0);
        bus.pkt_valid = 1'b0;

        // Soft reset abort: only the selected port's soft reset matters
        bus.fifo_empty = 3'b101;
        bus.data_in    = 2'd1;
        bus.pkt_valid  = 1'b1;
        step("sr_wte", S_WTE);
        bus.pkt_valid = 1'b0;
        check("sr_sel", 8'(bus.sel_addr), 8'd1);
        bus.soft_reset = 3'b001;
        step("sr_other_port", S_WTE);
        bus.soft_reset = 3'b010;
        step("sr_abort", S_DEC);
        bus.data_in   = 2'd0;
        bus.pkt_valid = 1'b1;
        step("sr_ignored_dec", S_LFD);
        bus.pkt_valid  = 1'b0;
        bus.soft_reset = 3'b000;
        step("sr_after_ld", S_LD);
        step("sr_after_lp", S_LP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
